// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular FIFO of {PC, instruction} pairs between
// fetch and decode, first-word-fall-through output, synchronous flush.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_ins,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_ins,
  output logic [WIDTH-1:0] out_pcp4,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned ENT_W = 2 * WIDTH;

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic [ENT_W-1:0] w_head;

  // Handshake qualification; flush discards any same-cycle push or pop
  always_comb begin
    in_ready  = (r_count != CNT_W'(DEPTH));
    out_valid = (r_count != '0);
    w_push    = in_valid & in_ready & ~flush;
    w_pop     = out_valid & out_ready & ~flush;
  end

  // Head presentation; an empty queue reads as PC 0 / instruction 0
  always_comb begin
    w_head   = r_mem[r_rd_ptr];
    out_pc   = '0;
    out_ins  = '0;
    if (out_valid) begin
      out_pc  = w_head[ENT_W-1:WIDTH];
      out_ins = w_head[WIDTH-1:0];
    end
    out_pcp4 = out_pc + WIDTH'(4);
    count    = r_count;
  end

  // Storage write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_pc, in_ins};
    end
  end

  // Pointers and occupancy; flush has priority over push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: the stimulus side commits expected entries
// to a reference queue, a negedge monitor compares the DUT head against it.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 3;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] ins;
  } ent_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_pc;
  logic [WIDTH-1:0] in_ins;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_pc;
  logic [WIDTH-1:0] out_ins;
  logic [WIDTH-1:0] out_pcp4;
  logic             flush;
  logic [CNT_W-1:0] count;

  int   n_checks;
  int   n_errors;
  ent_t exp_q[$];
  logic pend_push;
  logic pend_flush;
  ent_t pend_e;

  fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pc    (in_pc),
    .in_ins   (in_ins),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .out_ins  (out_ins),
    .out_pcp4 (out_pcp4),
    .flush    (flush),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare every mid-cycle view against the reference queue
  always @(negedge clk) begin
    if (rst_n) begin
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
      if (exp_q.size() != 0) begin
        chk("out_pc", out_pc, exp_q[0].pc);
        chk("out_ins", out_ins, exp_q[0].ins);
        chk("out_pcp4", out_pcp4, exp_q[0].pc + 32'd4);
        if (out_ready && !flush) void'(exp_q.pop_front());
      end else begin
        chk("empty_pc", out_pc, 32'h0);
        chk("empty_ins", out_ins, 32'h0);
        chk("empty_pcp4", out_pcp4, 32'h4);
      end
    end
  end

  // One clock: commit last cycle's push/flush to the model, then drive new inputs
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                     input logic ordy, input logic fl);
    @(posedge clk);
    if (pend_flush) exp_q.delete();
    else if (pend_push) exp_q.push_back(pend_e);
    #1;
    in_valid  = v;
    in_pc     = pc;
    in_ins    = ins;
    out_ready = ordy;
    flush     = fl;
    pend_flush = fl;
    pend_push  = v && !fl && (exp_q.size() != DEPTH);
    pend_e     = '{pc: pc, ins: ins};
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, ordy, 1'b0);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    pend_push  = 1'b0;
    pend_flush = 1'b0;
    pend_e     = '0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_pc      = '0;
    in_ins     = '0;
    out_ready  = 1'b0;
    flush      = 1'b0;

    // Reset state
    #12;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_pcp4", out_pcp4, 32'h4);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // T1: three entries then an asynchronous reset pulse between edges
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'(i * 4), 32'h500 + 32'(i), 1'b0, 1'b0);
    idle(1'b0, 1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    pend_push = 1'b0;
    #1;
    chk("t1_count", 32'(count), 32'h0);
    chk("t1_out_valid", 32'(out_valid), 32'h0);
    chk("t1_in_ready", 32'(in_ready), 32'h1);
    rst_n = 1'b1;

    // T2: fill, overfill attempt, then drain in order
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'(i * 4), 32'h13 + 32'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'h10, 32'h17, 1'b0, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 5);

    // T3: simultaneous push and pop at count 2
    cyc(1'b1, 32'h200, 32'hA0, 1'b0, 1'b0);
    cyc(1'b1, 32'h204, 32'hA1, 1'b0, 1'b0);
    cyc(1'b1, 32'h208, 32'hA2, 1'b1, 1'b0);
    cyc(1'b1, 32'h20C, 32'hA3, 1'b1, 1'b0);
    idle(1'b1, 4);

    // T4: flush with a push attempt, then a fresh push
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h300 + 32'(i * 4), 32'hB0 + 32'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'h30C, 32'hB3, 1'b1, 1'b1);
    cyc(1'b1, 32'h100, 32'hC0, 1'b0, 1'b0);
    idle(1'b0, 2);
    idle(1'b1, 2);

    // T5: ten entries at full rate through the wrap
    for (int i = 0; i < 10; i++) cyc(1'b1, 32'h400 + 32'(i * 4), 32'hD0 + 32'(i), 1'b1, 1'b0);
    idle(1'b1, 3);

    // T6: pop when empty, PC+4 wrap
    idle(1'b1, 2);
    cyc(1'b1, 32'hFFFF_FFFC, 32'h0000_0013, 1'b0, 1'b0);
    idle(1'b0, 2);
    idle(1'b1, 2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 99) < 65), $urandom, $urandom,
          1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 4));
    end
    idle(1'b1, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
